// File: rtl/mult_seq.sv
// Iterative signed WIDTHxWIDTH Booth multiplier with a start/ready/exception handshake.
// Define MULT_SEQ_BOOTH4_EN for radix-4 recoding (WIDTH/2 steps); the default build uses radix-2 (WIDTH steps).
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             ready,
  output logic             exception,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULT_SEQ_BOOTH4_EN
  localparam int STEPS = WIDTH / 2;
  localparam int AW    = WIDTH + 2;
`else
  localparam int STEPS = WIDTH;
  localparam int AW    = WIDTH + 1;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_next;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;
  logic [AW-1:0]    upper;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum;
  logic             last_step;

  assign last_step = (count == CW'(STEPS - 1));
  assign busy      = (state == BUSY);
  assign ready     = (state == DONE);

  // One Booth step: the recoded partial product is added to the sign-extended
  // upper half, and the sum's extra top bits become the new sign after the shift.
  always_comb begin
    addend = '0;
`ifdef MULT_SEQ_BOOTH4_EN
    upper = {{2{acc[2*WIDTH]}}, acc[2*WIDTH:WIDTH+1]};
    case (acc[2:0])
      3'b001, 3'b010: addend = {{2{mcand[WIDTH-1]}}, mcand};
      3'b011:         addend = {mcand[WIDTH-1], mcand, 1'b0};
      3'b100:         addend = -{mcand[WIDTH-1], mcand, 1'b0};
      3'b101, 3'b110: addend = -{{2{mcand[WIDTH-1]}}, mcand};
      default:        addend = '0;
    endcase
    sum      = upper + addend;
    acc_next = {sum, acc[WIDTH:2]};
`else
    upper = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   addend = {mcand[WIDTH-1], mcand};
      2'b10:   addend = -{mcand[WIDTH-1], mcand};
      default: addend = '0;
    endcase
    sum      = upper + addend;
    acc_next = {sum, acc[WIDTH:1]};
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    state_next = enable ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs only change on completion, so they hold across idle and busy periods.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      mcand     <= '0;
      count     <= '0;
      result    <= '0;
      result_hi <= '0;
      exception <= 1'b0;
    end else if ((state == IDLE || state == DONE) && enable) begin
      mcand <= multiplicand;
      acc   <= {{WIDTH{1'b0}}, multiplier, 1'b0};
      count <= '0;
    end else if (state == BUSY) begin
      acc   <= acc_next;
      count <= count + 1'b1;
      if (last_step) begin
        result    <= acc_next[WIDTH:1];
        result_hi <= acc_next[2*WIDTH:WIDTH+1];
        exception <= (acc_next[2*WIDTH:WIDTH+1] != {WIDTH{acc_next[WIDTH]}});
      end
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: expected products are queued at start and compared when ready pulses.
module tb_mult_seq;

`ifdef MULT_SEQ_BOOTH4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        exc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        ready;
  logic        exception;
  logic        busy;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  mult_seq #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .result(result),
    .result_hi(result_hi),
    .ready(ready),
    .exception(exception),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint p;
    p     = longint'($signed(a)) * longint'($signed(b));
    r.lo  = p[31:0];
    r.hi  = p[63:32];
    r.exc = (r.hi != {32{r.lo[31]}});
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives a start pulse that is sampled on the next posedge (edge E).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit track);
    enable       = 1'b1;
    multiplicand = a;
    multiplier   = b;
    if (track) scoreboard.push_back(model(a, b));
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic waitForReady(input string tag, input int startEdges);
    int   edges;
    bit   got;
    bit   busyBad;
    exp_t e;
    edges   = startEdges;
    got     = 0;
    busyBad = 0;
    while (!got && edges < LAT + 8) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (ready) got = 1;
      else if (!busy) busyBad = 1;
    end
    checkOutput({tag, " ready"}, 64'(got), 64'd1);
    checkOutput({tag, " latency"}, 64'(edges), 64'(LAT));
    checkOutput({tag, " busy during op"}, 64'(busyBad), 64'd0);
    if (got) begin
      checkOutput({tag, " busy in done"}, 64'(busy), 64'd0);
      checkOutput({tag, " queue nonempty"}, 64'(scoreboard.size() > 0), 64'd1);
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput({tag, " result"}, 64'(result), 64'(e.lo));
        checkOutput({tag, " result_hi"}, 64'(result_hi), 64'(e.hi));
        checkOutput({tag, " exception"}, 64'(exception), 64'(e.exc));
      end
    end
  endtask

  task automatic watchNoReady(input string tag, input int cycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (ready) seen = 1;
    end
    checkOutput({tag, " no ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset result", 64'(result), 64'd0);
    checkOutput("reset result_hi", 64'(result_hi), 64'd0);
    checkOutput("reset ready", 64'(ready), 64'd0);
    checkOutput("reset exception", 64'(exception), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);

    applyStimulus(32'd6, 32'd7, 1'b1);
    checkOutput("t1 busy after start", 64'(busy), 64'd1);
    waitForReady("t1 6*7", 1);
    @(negedge clock);
    checkOutput("t1 ready one cycle", 64'(ready), 64'd0);
    checkOutput("t1 result held", 64'(result), 64'h2A);

    applyStimulus(32'hFFFFFFFD, 32'd5, 1'b1);
    waitForReady("t2 -3*5", 1);
    @(negedge clock);

    applyStimulus(32'h7FFFFFFF, 32'd2, 1'b1);
    waitForReady("t3 max*2", 1);
    @(negedge clock);

    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1);
    waitForReady("t4 min*-1", 1);
    @(negedge clock);
    applyStimulus(32'h80000000, 32'd1, 1'b1);
    checkOutput("t4 exception held during op", 64'(exception), 64'd1);
    waitForReady("t4 min*1", 1);
    @(negedge clock);

    // Enable while busy must be ignored; then a back-to-back start from DONE.
    applyStimulus(32'd9, 32'd9, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
    enable       = 1'b1;
    multiplicand = 32'd2;
    multiplier   = 32'd2;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    waitForReady("t5 9*9", 11);
    applyStimulus(32'd3, 32'd4, 1'b1);
    checkOutput("t5 ready dropped b2b", 64'(ready), 64'd0);
    checkOutput("t5 busy b2b", 64'(busy), 64'd1);
    waitForReady("t5 3*4", 1);
    watchNoReady("t5 idle", LAT + 5);

    // Reset in the middle of an operation aborts it.
    applyStimulus(32'd100, 32'd100, 1'b0);
    for (int i = 0; i < 14; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("t6 result cleared", 64'(result), 64'd0);
    checkOutput("t6 result_hi cleared", 64'(result_hi), 64'd0);
    checkOutput("t6 exception cleared", 64'(exception), 64'd0);
    checkOutput("t6 busy cleared", 64'(busy), 64'd0);
    checkOutput("t6 ready cleared", 64'(ready), 64'd0);
    watchNoReady("t6 aborted", LAT + 5);
    applyStimulus(32'd1, 32'hFFFFFFFF, 1'b1);
    waitForReady("t6 1*-1", 1);

    checkOutput("scoreboard drained", 64'(scoreboard.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
